// File: rtl/memory_lookup_reader.sv
// rtl/memory_lookup_reader.sv - key lookup scanner over the flattened cell array
// Scans one cell per cycle; lowest matching used cell wins.
module memory_lookup_reader #(
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 64,
    parameter int NUM_CELLS   = 8,
    localparam int IDX_WIDTH  = $clog2(NUM_CELLS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [KEY_WIDTH-1:0]         req_key,
    input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_keys_in,
    input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_values_in,
    input  logic [NUM_CELLS-1:0]         cell_used_in,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         resp_hit,
    output logic [VALUE_WIDTH-1:0]       resp_value,
    output logic [IDX_WIDTH-1:0]         resp_index,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   idx;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [KEY_WIDTH-1:0]   cur_key;
    logic [VALUE_WIDTH-1:0] cur_value;
    logic                   cur_used;
    logic                   match;
    logic                   last_cell;

    assign req_ready = (state == IDLE);

    // Cells are sampled live; only the cell under idx this cycle matters.
    always_comb begin
        cur_key   = cell_keys_in[int'(idx)*KEY_WIDTH +: KEY_WIDTH];
        cur_value = cell_values_in[int'(idx)*VALUE_WIDTH +: VALUE_WIDTH];
        cur_used  = cell_used_in[idx];
        match     = cur_used && (cur_key == key_q);
        last_cell = (idx == IDX_WIDTH'(NUM_CELLS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            key_q      <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_value <= '0;
            resp_index <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key_q <= req_key;
                        busy  <= 1'b1;
                        if (req_key == '0) begin
                            // Key 0 marks an unused cell, so it can never hit.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_hit   <= 1'b0;
                            resp_value <= '0;
                            resp_index <= '0;
                        end else begin
                            idx   <= '0;
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (match) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_value <= cur_value;
                        resp_index <= idx;
                    end else if (last_cell) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_value <= '0;
                        resp_index <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_lookup_reader.sv
// tb/tb_memory_lookup_reader.sv - directed scoreboard bench for memory_lookup_reader
module tb_memory_lookup_reader;

    localparam int KW = 8;
    localparam int VW = 64;
    localparam int NC = 8;
    localparam int IW = $clog2(NC);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [KW-1:0] req_key;
    logic [NC*KW-1:0] cell_keys_in;
    logic [NC*VW-1:0] cell_values_in;
    logic [NC-1:0] cell_used_in;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_hit;
    logic [VW-1:0] resp_value;
    logic [IW-1:0] resp_index;
    logic          busy;

    logic [KW-1:0] ck [NC];
    logic [VW-1:0] cv [NC];
    logic          cu [NC];

    typedef struct {
        logic          hit;
        logic [VW-1:0] value;
        logic [IW-1:0] index;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    memory_lookup_reader #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_CELLS(NC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .cell_keys_in(cell_keys_in), .cell_values_in(cell_values_in),
        .cell_used_in(cell_used_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_value(resp_value), .resp_index(resp_index), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        cell_keys_in   = '0;
        cell_values_in = '0;
        cell_used_in   = '0;
        for (int i = 0; i < NC; i++) begin
            cell_keys_in[i*KW +: KW]   = ck[i];
            cell_values_in[i*VW +: VW] = cv[i];
            cell_used_in[i]            = cu[i];
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cells();
        for (int i = 0; i < NC; i++) begin
            ck[i] = '0;
            cv[i] = '0;
            cu[i] = 1'b0;
        end
    endtask

    // Reference: lowest used cell with matching nonzero key.
    function automatic exp_t model(input logic [KW-1:0] k);
        exp_t e;
        e.hit = 1'b0;
        e.value = '0;
        e.index = '0;
        e.lat = (k == '0) ? 0 : NC;
        if (k != '0) begin
            for (int i = NC - 1; i >= 0; i--) begin
                if (cu[i] && ck[i] == k) begin
                    e.hit = 1'b1;
                    e.value = cv[i];
                    e.index = IW'(i);
                    e.lat = i + 1;
                end
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [KW-1:0] k);
        int n = 0;
        sb.push_back(model(k));
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        req_valid = 1'b1;
        req_key   = k;
        tick();
        req_valid = 1'b0;
        req_key   = KW'($urandom);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        int n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, VW'(n), VW'(e.lat));
        check({tag, "_hit"}, VW'(resp_hit), VW'(e.hit));
        check({tag, "_value"}, resp_value, e.value);
        check({tag, "_index"}, VW'(resp_index), VW'(e.index));
        check({tag, "_busy"}, VW'(busy), VW'(1));
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_rv_drop"}, VW'(resp_valid), VW'(0));
        check({tag, "_ready_back"}, VW'(req_ready), VW'(1));
    endtask

    initial begin
        logic [VW-1:0] held_value;
        logic [IW-1:0] held_index;
        rst = 1'b1;
        req_valid = 1'b0;
        req_key = '0;
        resp_ready = 1'b0;
        clear_cells();
        tick();
        tick();
        rst = 1'b0;

        check("rst_resp_valid", VW'(resp_valid), VW'(0));
        check("rst_hit", VW'(resp_hit), VW'(0));
        check("rst_value", resp_value, VW'(0));
        check("rst_index", VW'(resp_index), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_req_ready", VW'(req_ready), VW'(1));

        ck[3] = 8'h2A; cv[3] = 64'hDEAD_BEEF; cu[3] = 1'b1;
        issue(8'h2A);
        collect("hit3");
        release_resp("hit3");

        for (int i = 0; i < NC; i++) begin
            ck[i] = KW'(8'h60 + i); cv[i] = VW'(i * 3 + 7); cu[i] = 1'b1;
        end
        issue(8'h55);
        collect("miss");
        release_resp("miss");

        issue(8'h00);
        collect("key0");
        release_resp("key0");

        clear_cells();
        ck[2] = 8'h11; cv[2] = 64'h2222; cu[2] = 1'b1;
        ck[5] = 8'h11; cv[5] = 64'h5555; cu[5] = 1'b1;
        ck[1] = 8'h11; cv[1] = 64'h1111; cu[1] = 1'b0;
        issue(8'h11);
        collect("dup");

        held_value = resp_value;
        held_index = resp_index;
        req_valid = 1'b1;
        req_key = 8'h11;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_valid", VW'(resp_valid), VW'(1));
            check("stall_value", resp_value, held_value);
            check("stall_index", VW'(resp_index), VW'(held_index));
            check("stall_req_ready", VW'(req_ready), VW'(0));
        end
        req_valid = 1'b0;
        release_resp("stall");
        tick();
        check("stall_no_second", VW'(resp_valid), VW'(0));
        check("stall_idle_busy", VW'(busy), VW'(0));

        clear_cells();
        for (int i = 0; i < NC; i++) begin
            ck[i] = 8'h70; cu[i] = 1'b1;
        end
        ck[7] = 8'h33; cv[7] = 64'h7777;
        sb.push_back(model(8'h33));
        req_valid = 1'b1;
        req_key = 8'h33;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mid_busy", VW'(busy), VW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        check("abort_valid", VW'(resp_valid), VW'(0));
        check("abort_busy", VW'(busy), VW'(0));
        check("abort_ready", VW'(req_ready), VW'(1));
        check("abort_hit", VW'(resp_hit), VW'(0));
        for (int c = 0; c < 10; c++) begin
            tick();
            check("abort_silent", VW'(resp_valid), VW'(0));
        end
        issue(8'h33);
        collect("after_abort");
        release_resp("after_abort");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NC; i++) begin
                ck[i] = KW'($urandom_range(0, 5));
                cv[i] = {$urandom, $urandom};
                cu[i] = 1'($urandom_range(0, 1));
            end
            issue(KW'($urandom_range(0, 5)));
            collect("rand");
            release_resp("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
